// File: rtl/typeracer_pkg.sv
// Shared TypeRacer constants: letter scan-code table, special keys and the
// ghost typer FSM state encoding. The in-game scorer decodes the same codes.
package typeracer_pkg;

    localparam int         NUM_LETTERS = 26;
    localparam logic [8:0] SPACE_CODE  = 9'd41;
    localparam logic [8:0] BACK_CODE   = 9'd102;

    // Scan code for letters a..z, slot 0 holds 'a'.
    localparam logic [8:0] LETTER_SCAN [NUM_LETTERS] = '{
        9'd28, 9'd50, 9'd33, 9'd35, 9'd36, 9'd43, 9'd52, 9'd51, 9'd67,
        9'd59, 9'd66, 9'd75, 9'd58, 9'd49, 9'd68, 9'd77, 9'd21, 9'd45,
        9'd27, 9'd44, 9'd60, 9'd42, 9'd29, 9'd34, 9'd53, 9'd26
    };

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HOLD,
        RELEASE,
        GAP,
        DONE
    } ghost_state_e;

endpackage

// File: rtl/scancode_lut.sv
// Letter code (1=a .. 26=z) to keyboard scan code. Codes outside 1..26 are
// flagged invalid and map to scan code 0.
module scancode_lut
    import typeracer_pkg::*;
(
    input  logic [4:0] letter_i,
    output logic [8:0] scan_o,
    output logic       valid_o
);

    logic [4:0] slot;

    // Table lookup with range check
    always_comb begin
        valid_o = (letter_i >= 5'd1) && (letter_i <= 5'd26);
        slot    = letter_i - 5'd1;
        scan_o  = valid_o ? LETTER_SCAN[slot] : 9'd0;
    end

endmodule

// File: rtl/ghost_typer.sv
// Ghost typer: replays a latched word as press/release key events on the
// game tick, finishing with SPACE. Optional typo injection is enabled by
// defining GHOST_TYPO_EN (every TYPO_PERIOD-th letter is typed as wrong
// letter, BACK, correct letter).
//
// state   | meaning
// IDLE    | waiting for start; clears busy
// PRESS   | emit press event for the current key
// HOLD    | key held for HOLD_TICKS ticks
// RELEASE | emit release event, advance to next key
// GAP     | GAP_TICKS idle ticks between keys
// DONE    | one-cycle done pulse
module ghost_typer
    import typeracer_pkg::*;
#(
    parameter int HOLD_TICKS  = 2,
    parameter int GAP_TICKS   = 1,
    parameter int TYPO_PERIOD = 4
) (
    input  logic          clk_div,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic [74:0]   word,
    input  logic [4:0]    wordnum,
    output logic [127:0]  key_down,
    output logic [8:0]    last_change,
    output logic          key_valid,
    output logic          busy,
    output logic          done,
    output logic [10:0]   keys_sent
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] GAP_LOAD  = (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;

    generate
        if (HOLD_TICKS < 1 || GAP_TICKS < 0 || TYPO_PERIOD < 2) begin : g_bad_param
            $error("ghost_typer: illegal HOLD_TICKS/GAP_TICKS/TYPO_PERIOD");
        end
    endgenerate

    ghost_state_e  state_q, state_d;
    logic [15:0]   tick_q, tick_d;
    logic [3:0]    idx_q, idx_d;
    logic [1:0]    sub_q, sub_d;
    logic          fin_q, fin_d;
    logic [79:0]   word_q, word_d;
    logic [3:0]    num_q, num_d;
    logic [127:0]  key_down_q, key_down_d;
    logic [8:0]    last_q, last_d;
    logic          kv_q, kv_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [10:0]   sent_q, sent_d;

    logic [4:0]    cur_letter;
    logic [4:0]    wrong_letter;
    logic [4:0]    lut_in;
    logic [8:0]    lut_scan;
    logic          lut_valid;
    logic          typo_slot;
    logic          typo;
    logic          is_space;
    logic [8:0]    code;

    // word_q carries a zero pad above letter 14 so idx 15 reads an
    // invalid letter and falls through to SPACE.
    assign cur_letter = word_q[5*idx_q +: 5];

`ifdef GHOST_TYPO_EN
    assign typo_slot = (32'(idx_q) % TYPO_PERIOD) == (TYPO_PERIOD - 1);
`else
    assign typo_slot = 1'b0;
`endif

    // Wrong letter is the next one alphabetically; invalid codes stay invalid
    always_comb begin
        if (cur_letter == 5'd26)
            wrong_letter = 5'd1;
        else if (cur_letter == 5'd0)
            wrong_letter = 5'd0;
        else
            wrong_letter = cur_letter + 5'd1;
    end

    assign lut_in = (typo_slot && sub_q == 2'd0) ? wrong_letter : cur_letter;

    scancode_lut u_lut (
        .letter_i (lut_in),
        .scan_o   (lut_scan),
        .valid_o  (lut_valid)
    );

    // Key selector: SPACE once letters run out or hit an invalid code
    always_comb begin
        is_space = (idx_q >= num_q) || !lut_valid;
        typo     = typo_slot && !is_space;
        if (is_space)
            code = SPACE_CODE;
        else if (typo && sub_q == 2'd1)
            code = BACK_CODE;
        else
            code = lut_scan;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        idx_d      = idx_q;
        sub_d      = sub_q;
        fin_d      = fin_q;
        word_d     = word_q;
        num_d      = num_q;
        key_down_d = key_down_q;
        last_d     = last_q;
        busy_d     = busy_q;
        sent_d     = sent_q;
        kv_d       = 1'b0;
        done_d     = 1'b0;

        if (!pause) begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        word_d  = {5'd0, word};
                        num_d   = (wordnum > 5'd15) ? 4'd15 : wordnum[3:0];
                        idx_d   = 4'd0;
                        sub_d   = 2'd0;
                        fin_d   = 1'b0;
                        sent_d  = 11'd0;
                        state_d = PRESS;
                    end
                end
                PRESS: begin
                    kv_d       = 1'b1;
                    last_d     = code;
                    key_down_d = '0;
                    key_down_d[code[6:0]] = 1'b1;
                    busy_d     = 1'b1;
                    if (sent_q != 11'h7FF)
                        sent_d = sent_q + 11'd1;
                    tick_d     = HOLD_LOAD;
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (tick_q == 16'd0)
                        state_d = RELEASE;
                    else
                        tick_d = tick_q - 16'd1;
                end
                RELEASE: begin
                    kv_d       = 1'b1;
                    last_d     = code;
                    key_down_d = '0;
                    if (is_space) begin
                        fin_d = 1'b1;
                    end else if (typo && sub_q != 2'd2) begin
                        sub_d = sub_q + 2'd1;
                    end else begin
                        sub_d = 2'd0;
                        idx_d = idx_q + 4'd1;
                    end
                    if (GAP_TICKS == 0) begin
                        state_d = is_space ? DONE : PRESS;
                    end else begin
                        tick_d  = GAP_LOAD;
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (tick_q == 16'd0)
                        state_d = fin_q ? DONE : PRESS;
                    else
                        tick_d = tick_q - 16'd1;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            idx_q      <= '0;
            sub_q      <= '0;
            fin_q      <= 1'b0;
            word_q     <= '0;
            num_q      <= '0;
            key_down_q <= '0;
            last_q     <= '0;
            kv_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            sub_q      <= sub_d;
            fin_q      <= fin_d;
            word_q     <= word_d;
            num_q      <= num_d;
            key_down_q <= key_down_d;
            last_q     <= last_d;
            kv_q       <= kv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sent_q     <= sent_d;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_q;
    assign key_valid   = kv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign keys_sent   = sent_q;

endmodule

// File: tb/tb_ghost_typer.sv
// Bench for ghost_typer: an event-schedule model (key k pressed at tick
// 1+kP, released HOLD+1 ticks later, done after the last key) is compared
// against every DUT output each cycle, plus literal event timelines.
module tb_ghost_typer;

    localparam int HOLD = 2;
    localparam int GAP  = 1;
    localparam int TP   = 4;
    localparam int P    = 2 + HOLD + GAP;

    logic          clk_div = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [74:0]   word = '0;
    logic [4:0]    wordnum = '0;
    logic [127:0]  key_down;
    logic [8:0]    last_change;
    logic          key_valid;
    logic          busy;
    logic          done;
    logic [10:0]   keys_sent;

    ghost_typer #(.HOLD_TICKS(HOLD), .GAP_TICKS(GAP), .TYPO_PERIOD(TP)) dut (
        .clk_div     (clk_div),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .word        (word),
        .wordnum     (wordnum),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .busy        (busy),
        .done        (done),
        .keys_sent   (keys_sent)
    );

    always #5 clk_div = ~clk_div;

    int scan_tab [27] = '{0, 28, 50, 33, 35, 36, 43, 52, 51, 67, 59, 66, 75, 58,
                          49, 68, 77, 21, 45, 27, 44, 60, 42, 29, 34, 53, 26};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int s0       = 0;
    int ev_cyc[$];
    int ev_code[$];
    int done_rel = -1;

    // reference model state
    bit            m_run = 1'b0;
    int            m_t = 0;
    int            m_k, m_r;
    int            m_keys[$];
    logic          exp_kv = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic [8:0]    exp_last = '0;
    logic [127:0]  exp_kd = '0;
    logic [10:0]   exp_sent = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic build_keys(input logic [74:0] w, input logic [4:0] wn);
        int n, l;
        m_keys.delete();
        n = (wn > 5'd15) ? 15 : int'(wn);
        for (int i = 0; i < n; i++) begin
            l = int'(w[5*i +: 5]);
            if (l < 1 || l > 26) break;
`ifdef GHOST_TYPO_EN
            if (i % TP == TP - 1) begin
                m_keys.push_back(scan_tab[(l % 26) + 1]);
                m_keys.push_back(102);
            end
`endif
            m_keys.push_back(scan_tab[l]);
        end
        m_keys.push_back(41);
    endtask

    function automatic logic [74:0] mkw(input int l0, input int l1, input int l2,
                                        input int l3, input int l4);
        logic [74:0] w;
        w = '0;
        w[4:0]   = 5'(l0);
        w[9:5]   = 5'(l1);
        w[14:10] = 5'(l2);
        w[19:15] = 5'(l3);
        w[24:20] = 5'(l4);
        return w;
    endfunction

    always @(posedge clk_div) cyc <= cyc + 1;

    // Model: advance the word's schedule on every unpaused tick
    always @(posedge clk_div or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; exp_kv = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_last = '0; exp_kd = '0; exp_sent = '0;
        end else begin
            exp_kv   = 1'b0;
            exp_done = 1'b0;
            if (!pause) begin
                if (!m_run) begin
                    exp_busy = 1'b0;
                    if (start) begin
                        build_keys(word, wordnum);
                        m_run = 1'b1;
                        m_t = 0;
                        exp_sent = '0;
                    end
                end else begin
                    m_t++;
                    if (m_t == 1 + m_keys.size() * P) begin
                        exp_done = 1'b1;
                        m_run = 1'b0;
                    end else begin
                        m_k = (m_t - 1) / P;
                        m_r = (m_t - 1) % P;
                        if (m_r == 0) begin
                            exp_kv = 1'b1;
                            exp_last = 9'(m_keys[m_k]);
                            exp_kd = '0;
                            exp_kd[m_keys[m_k]] = 1'b1;
                            exp_busy = 1'b1;
                            if (exp_sent != 11'h7FF) exp_sent = exp_sent + 11'd1;
                        end else if (m_r == 1 + HOLD) begin
                            exp_kv = 1'b1;
                            exp_last = 9'(m_keys[m_k]);
                            exp_kd = '0;
                        end
                    end
                end
            end
        end
    end

    // Compare every output each cycle and log DUT events
    always @(negedge clk_div) begin
        #2;
        chk("key_down",    key_down,    exp_kd);
        chk("last_change", 128'(last_change), 128'(exp_last));
        chk("key_valid",   128'(key_valid),   128'(exp_kv));
        chk("busy",        128'(busy),        128'(exp_busy));
        chk("done",        128'(done),        128'(exp_done));
        chk("keys_sent",   128'(keys_sent),   128'(exp_sent));
        if (key_valid === 1'b1) begin
            ev_cyc.push_back(cyc - s0);
            ev_code.push_back(int'(last_change));
        end
        if (done === 1'b1) done_rel = cyc - s0;
    end

    task automatic check_ev(input string name, input int i, input int ecyc, input int ecode);
        if (i < ev_cyc.size()) begin
            chk({name, "_cycle"}, 128'(ev_cyc[i]), 128'(ecyc));
            chk({name, "_code"},  128'(ev_code[i]), 128'(ecode));
        end else begin
            n_checks++;
            $display("FAIL %s: event %0d missing, expected code %0d at cycle %0d", name, i, ecode, ecyc);
        end
    endtask

    task automatic begin_word(input logic [74:0] w, input logic [4:0] wn, input bit hold_start);
        @(negedge clk_div);
        word = w; wordnum = wn; start = 1'b1;
        s0 = cyc + 1;
        ev_cyc.delete(); ev_code.delete(); done_rel = -1;
        @(negedge clk_div);
        if (!hold_start) start = 1'b0;
    endtask

    task automatic rand_word(output logic [74:0] w);
        w = '0;
        for (int i = 0; i < 15; i++)
            w[5*i +: 5] = ($urandom_range(0, 29) == 0) ? 5'($urandom_range(27, 32) % 32)
                                                      : 5'($urandom_range(1, 26));
    endtask

    int cat_cyc  [8] = '{1, 4, 6, 9, 11, 14, 16, 19};
    int cat_code [8] = '{33, 33, 28, 28, 44, 44, 41, 41};
    logic [74:0] rw;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk_div);
        rst = 1'b0;
        repeat (2) @(negedge clk_div);
        chk("reset_keys_sent", 128'(keys_sent), 128'(0));

        // "cat": literal timeline
        begin_word(mkw(3, 1, 20, 0, 0), 5'd3, 1'b0);
        repeat (25) @(negedge clk_div);
        chk("cat_events", 128'(ev_cyc.size()), 128'(8));
        for (int i = 0; i < 8; i++) check_ev("cat", i, cat_cyc[i], cat_code[i]);
        chk("cat_done", 128'(done_rel), 128'(21));
        chk("cat_keys_sent", 128'(keys_sent), 128'(4));

        // invalid letter at idx 1 ends the word early
        begin_word(mkw(8, 0, 3, 4, 5), 5'd5, 1'b0);
        repeat (15) @(negedge clk_div);
        chk("early_events", 128'(ev_cyc.size()), 128'(4));
        check_ev("early_h", 0, 1, 51);
        check_ev("early_space", 2, 6, 41);
        chk("early_done", 128'(done_rel), 128'(11));

        // wordnum = 0: SPACE only
        begin_word(mkw(3, 1, 20, 0, 0), 5'd0, 1'b0);
        repeat (10) @(negedge clk_div);
        check_ev("empty_space", 0, 1, 41);
        chk("empty_done", 128'(done_rel), 128'(6));

        // pause over cycles 2..6 during the first HOLD
        begin_word(mkw(3, 1, 20, 0, 0), 5'd3, 1'b0);
        repeat (2) @(negedge clk_div);
        pause = 1'b1;
        repeat (5) @(negedge clk_div);
        pause = 1'b0;
        repeat (25) @(negedge clk_div);
        check_ev("pause_rel", 1, 9, 33);
        check_ev("pause_press", 2, 11, 28);
        chk("pause_done", 128'(done_rel), 128'(26));

        // start held high: restart only after IDLE
        begin_word(mkw(3, 1, 20, 0, 0), 5'd3, 1'b1);
        repeat (24) @(negedge clk_div);
        start = 1'b0;
        check_ev("held_last", 7, 19, 41);
        check_ev("held_restart", 8, 23, 33);
        repeat (26) @(negedge clk_div);
        chk("held_done2", 128'(done_rel), 128'(43));

`ifdef GHOST_TYPO_EN
        // "dogs" with a typo on idx 3: d o g t BACK s SPACE
        begin_word(mkw(4, 15, 7, 19, 0), 5'd4, 1'b0);
        repeat (40) @(negedge clk_div);
        check_ev("typo_wrong", 6, 16, 44);
        check_ev("typo_back", 8, 21, 102);
        check_ev("typo_fix", 10, 26, 27);
        check_ev("typo_space", 12, 31, 41);
        chk("typo_done", 128'(done_rel), 128'(36));
        chk("typo_keys_sent", 128'(keys_sent), 128'(7));
`endif

        // reset mid-HOLD
        begin_word(mkw(3, 1, 20, 0, 0), 5'd3, 1'b0);
        repeat (3) @(negedge clk_div);
        rst = 1'b1;
        #2;
        chk("rst_key_down", key_down, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(negedge clk_div);
        rst = 1'b0;
        repeat (12) @(negedge clk_div);
        chk("rst_events", 128'(ev_cyc.size()), 128'(1));

        // randomized traffic with pauses and occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_div);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 599) == 0) rst = 1'b1;
            pause = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            if (start) begin
                rand_word(rw);
                word = rw;
                wordnum = 5'($urandom_range(0, 20));
            end
        end
        start = 1'b0; pause = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk_div);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
